// File: rtl/lmg_pkg.sv
// Shared types and constants for the legal-move-generator output packer.
// Slot layout: {invalid flag, move payload}; slot 0 occupies the least significant bits.
package lmg_pkg;

  localparam int unsigned MOVE_W     = 18;
  localparam int unsigned SLOT_W     = MOVE_W + 1;
  localparam int unsigned SLOTS      = 8;
  localparam int unsigned WORD_W     = SLOTS * SLOT_W;
  localparam int unsigned SLOT_CNT_W = $clog2(SLOTS);
  localparam int unsigned MOVE_CNT_W = 8;

  typedef struct packed {
    logic              inv;
    logic [MOVE_W-1:0] move;
  } slot_t;

  typedef slot_t [SLOTS-1:0] word_t;

  localparam slot_t EMPTY_SLOT   = '{inv: 1'b1, move: '0};
  localparam word_t INVALID_WORD = {SLOTS{EMPTY_SLOT}};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_FLUSH   = 3'd2,
    ST_TERM    = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Bit position of the invalid flag of slot k within a packed word.
  function automatic int unsigned inv_bit(input int unsigned k);
    return k * SLOT_W + MOVE_W;
  endfunction

endpackage

// File: rtl/lmg_word_fifo.sv
// Word FIFO between the move packer and the control-block reader.
// Registered read data and flags; a pop while empty presents INVALID_WORD.
module lmg_word_fifo
  import lmg_pkg::*;
#(
  parameter int unsigned DEPTH = 32
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_clr,
  input  logic  i_push,
  input  word_t i_wdata,
  input  logic  i_pop,
  output word_t o_rdata,
  output logic  o_full,
  output logic  o_empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  word_t            r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_full;
  logic             r_empty;
  word_t            r_rdata;
  logic             w_push_ok;
  logic             w_pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_push_ok = i_push & ~r_full;
  assign w_pop_ok  = i_pop & ~r_empty;
  assign w_cnt_nxt = r_cnt + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);

  // Storage array carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push_ok && !i_clr) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_rdata  <= INVALID_WORD;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_rdata  <= INVALID_WORD;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      if (i_pop) begin
        r_rdata <= r_empty ? INVALID_WORD : r_mem[r_rd_ptr];
      end
      r_cnt   <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == CNT_W'(DEPTH));
      r_empty <= (w_cnt_nxt == '0);
    end
  end

  assign o_rdata = r_rdata;
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/lmg_move_packer.sv
// Packs generator moves 8 per word into a FIFO and closes each list with INVALID_WORD.
// Optional LMG_MOVE_COUNT_EN adds a saturating accepted-move counter output.
module lmg_move_packer
  import lmg_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mv_valid,
  input  logic [MOVE_W-1:0]     mv_data,
  output logic                  mv_ready,
  input  logic                  gen_done,
  input  logic                  rden,
  output logic [WORD_W-1:0]     fifoOut,
  output logic                  fifoEmpty,
`ifdef LMG_MOVE_COUNT_EN
  output logic [MOVE_CNT_W-1:0] move_count,
`endif
  output logic                  done
);

  state_e                r_state;
  state_e                w_state_nxt;
  word_t                 r_slots;
  word_t                 w_slots_nxt;
  word_t                 w_slot_fill;
  logic [SLOT_CNT_W-1:0] r_slot_cnt;
  logic [SLOT_CNT_W-1:0] w_slot_cnt_nxt;
  logic                  w_last_slot;
  logic                  w_mv_ready;
  logic                  w_accept;
  logic                  w_push;
  word_t                 w_push_data;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  word_t                 w_fifo_rdata;
  logic                  r_done;

  assign w_last_slot = (r_slot_cnt == SLOT_CNT_W'(SLOTS - 1));

  // Slot register with the incoming move dropped into the next free slot.
  always_comb begin
    w_slot_fill             = r_slots;
    w_slot_fill[r_slot_cnt] = '{inv: 1'b0, move: mv_data};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (start) begin
      w_state_nxt = ST_COLLECT;
    end else begin
      case (r_state)
        ST_IDLE:    w_state_nxt = ST_IDLE;
        ST_COLLECT: if (gen_done) w_state_nxt = ST_FLUSH;
        ST_FLUSH:   if ((r_slot_cnt == '0) || !w_fifo_full) w_state_nxt = ST_TERM;
        ST_TERM:    if (!w_fifo_full) w_state_nxt = ST_DONE;
        ST_DONE:    w_state_nxt = ST_DONE;
        default:    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Handshake, FIFO push and slot-register update; start discards the partial word.
  always_comb begin
    w_mv_ready     = 1'b0;
    w_accept       = 1'b0;
    w_push         = 1'b0;
    w_push_data    = INVALID_WORD;
    w_slots_nxt    = r_slots;
    w_slot_cnt_nxt = r_slot_cnt;
    if (r_state == ST_COLLECT) begin
      w_mv_ready = !(w_last_slot && w_fifo_full);
    end
    if (start) begin
      w_slots_nxt    = INVALID_WORD;
      w_slot_cnt_nxt = '0;
    end else begin
      case (r_state)
        ST_COLLECT: begin
          w_accept = mv_valid & w_mv_ready;
          if (w_accept) begin
            if (w_last_slot) begin
              w_push         = 1'b1;
              w_push_data    = w_slot_fill;
              w_slots_nxt    = INVALID_WORD;
              w_slot_cnt_nxt = '0;
            end else begin
              w_slots_nxt    = w_slot_fill;
              w_slot_cnt_nxt = r_slot_cnt + SLOT_CNT_W'(1);
            end
          end
        end
        ST_FLUSH: begin
          if ((r_slot_cnt != '0) && !w_fifo_full) begin
            w_push         = 1'b1;
            w_push_data    = r_slots;
            w_slots_nxt    = INVALID_WORD;
            w_slot_cnt_nxt = '0;
          end
        end
        ST_TERM: begin
          if (!w_fifo_full) begin
            w_push = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Unfilled slots always carry invalid=1, so a partial word is pushed as-is.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_slots    <= INVALID_WORD;
      r_slot_cnt <= '0;
      r_done     <= 1'b0;
    end else begin
      r_slots    <= w_slots_nxt;
      r_slot_cnt <= w_slot_cnt_nxt;
      r_done     <= (w_state_nxt == ST_DONE);
    end
  end

`ifdef LMG_MOVE_COUNT_EN
  logic [MOVE_CNT_W-1:0] r_move_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_move_cnt <= '0;
    end else if (start) begin
      r_move_cnt <= '0;
    end else if (w_accept && (r_move_cnt != '1)) begin
      r_move_cnt <= r_move_cnt + MOVE_CNT_W'(1);
    end
  end

  assign move_count = r_move_cnt;
`endif

  lmg_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_clr   (start),
    .i_push  (w_push),
    .i_wdata (w_push_data),
    .i_pop   (rden),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign mv_ready  = w_mv_ready;
  assign fifoOut   = w_fifo_rdata;
  assign fifoEmpty = w_fifo_empty;
  assign done      = r_done;

endmodule

// File: tb/tb_lmg_move_packer.sv
// Self-checking bench for lmg_move_packer with a 4-word FIFO so back-pressure is reachable.
// Expected words come from a list-chunking model; LMG_MOVE_COUNT_EN also checks move_count.
module tb_lmg_move_packer;

  localparam int TB_DEPTH = 4;
  localparam int NSLOT    = 8;
  localparam int MW       = 18;
  localparam int SW       = 19;
  localparam int WW       = 152;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic          mv_valid;
  logic [MW-1:0] mv_data;
  logic          mv_ready;
  logic          gen_done;
  logic          rden;
  logic [WW-1:0] fifoOut;
  logic          fifoEmpty;
  logic          done;
`ifdef LMG_MOVE_COUNT_EN
  logic [7:0]    move_count;
`endif

  logic [WW-1:0] inv_word;
  logic [MW-1:0] mv_q[$];
  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] obs_q[$];
  int            n_cmp;
  int            n_bad;
  bit            timed_out;

  lmg_move_packer #(
    .FIFO_DEPTH (TB_DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset_n),
    .start      (start),
    .mv_valid   (mv_valid),
    .mv_data    (mv_data),
    .mv_ready   (mv_ready),
    .gen_done   (gen_done),
    .rden       (rden),
    .fifoOut    (fifoOut),
    .fifoEmpty  (fifoEmpty),
`ifdef LMG_MOVE_COUNT_EN
    .move_count (move_count),
`endif
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WW-1:0] empty_word();
    logic [WW-1:0] w;
    w = '0;
    for (int k = 0; k < NSLOT; k++) w[SW*k+MW] = 1'b1;
    return w;
  endfunction

  // Reference: chunk the move list 8 at a time, pad with invalid slots, append terminator.
  function automatic void build_exp();
    logic [WW-1:0] w;
    int n;
    n = mv_q.size();
    exp_q.delete();
    for (int base = 0; base < n; base += NSLOT) begin
      w = inv_word;
      for (int k = 0; k < NSLOT; k++) begin
        if (base + k < n) begin
          w[SW*k+MW]    = 1'b0;
          w[SW*k +: MW] = mv_q[base+k];
        end
      end
      exp_q.push_back(w);
    end
    exp_q.push_back(inv_word);
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_gen_done();
    gen_done = 1'b1;
    @(negedge clk);
    gen_done = 1'b0;
  endtask

  task automatic send_move(input logic [MW-1:0] d, input bit last);
    int waitc;
    waitc    = 0;
    mv_valid = 1'b1;
    mv_data  = d;
    while (mv_ready !== 1'b1 && waitc < 300) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc >= 300) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_move_stall: mv_ready low for %0d cycles, required 1", waitc);
    end
    gen_done = last;
    @(negedge clk);
    mv_valid = 1'b0;
    gen_done = 1'b0;
  endtask

  // Sends mv_q; gen_done either rides on the last move or follows as its own pulse.
  task automatic drive_list(input bit coincident);
    int n;
    n = mv_q.size();
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_move(mv_q[i], coincident && (i == n - 1));
    end
    if (!(coincident && n > 0)) pulse_gen_done();
  endtask

  task automatic pop_one(output logic [WW-1:0] w);
    rden = 1'b1;
    @(negedge clk);
    rden = 1'b0;
    w = fifoOut;
  endtask

  // Pops into obs_q (pct% chance per cycle) until done is set and the FIFO is empty.
  task automatic drain(input int budget, input int pct);
    int cyc;
    logic [WW-1:0] w;
    cyc       = 0;
    timed_out = 1'b0;
    while (1) begin
      if (cyc >= budget) begin
        timed_out = 1'b1;
        break;
      end
      if (fifoEmpty === 1'b0 && $urandom_range(0, 99) < pct) begin
        pop_one(w);
        obs_q.push_back(w);
      end else if (fifoEmpty === 1'b1 && done === 1'b1) begin
        break;
      end else begin
        @(negedge clk);
      end
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    start    = 1'b0;
    mv_valid = 1'b0;
    mv_data  = '0;
    gen_done = 1'b0;
    rden     = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (fifoEmpty !== 1'b1) begin n_bad++; $display("FAIL reset_fifoEmpty: got %b expected 1", fifoEmpty); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if (mv_ready !== 1'b0) begin n_bad++; $display("FAIL reset_mv_ready: got %b expected 0", mv_ready); end
    n_cmp++; if (fifoOut !== inv_word) begin n_bad++; $display("FAIL reset_fifoOut: got %h expected %h", fifoOut, inv_word); end
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (mv_ready !== 1'b0) begin n_bad++; $display("FAIL idle_mv_ready: got %b expected 0", mv_ready); end
  endtask

  task automatic test_partial_word();
    mv_q = '{18'h00111, 18'h00222, 18'h00333};
    build_exp();
    obs_q.delete();
    pulse_start();
    drive_list(1'b0);
    drain(200, 100);
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL partial_drain_timeout: got timeout expected done"); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL partial_done: got %b expected 1", done); end
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL partial_word_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL partial_word%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_full_word();
    mv_q.delete();
    for (int i = 1; i <= 8; i++) mv_q.push_back(MW'(i));
    build_exp();
    obs_q.delete();
    pulse_start();
    drive_list(1'b1);
    drain(200, 100);
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL full_drain_timeout: got timeout expected done"); end
    n_cmp++; if (obs_q.size() != 2) begin n_bad++; $display("FAIL full_word_count: got %0d expected 2", obs_q.size()); end
    if (obs_q.size() > 0) begin
      n_cmp++; if (obs_q[0][17:0] !== 18'h1) begin n_bad++; $display("FAIL full_slot0: got %h expected 1", obs_q[0][17:0]); end
      n_cmp++; if (obs_q[0][150:133] !== 18'h8) begin n_bad++; $display("FAIL full_slot7: got %h expected 8", obs_q[0][150:133]); end
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL full_word%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_empty_list();
    logic [WW-1:0] w;
    int waitc;
    pulse_start();
    pulse_gen_done();
    waitc = 0;
    while (done !== 1'b1 && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL empty_done: got %b expected 1", done); end
    n_cmp++; if (fifoEmpty !== 1'b0) begin n_bad++; $display("FAIL empty_term_queued: got fifoEmpty=%b expected 0", fifoEmpty); end
    pop_one(w);
    n_cmp++; if (w !== inv_word) begin n_bad++; $display("FAIL empty_term_word: got %h expected %h", w, inv_word); end
    n_cmp++; if (fifoEmpty !== 1'b1) begin n_bad++; $display("FAIL empty_after_pop: got %b expected 1", fifoEmpty); end
    pop_one(w);
    n_cmp++; if (w !== inv_word) begin n_bad++; $display("FAIL empty_read_empty: got %h expected %h", w, inv_word); end
    n_cmp++; if (fifoEmpty !== 1'b1 || done !== 1'b1) begin n_bad++; $display("FAIL empty_hold: got fifoEmpty=%b done=%b expected 1/1", fifoEmpty, done); end
  endtask

  task automatic test_backpressure();
    logic [WW-1:0] w;
    mv_q.delete();
    for (int i = 0; i < 40; i++) mv_q.push_back(MW'($urandom));
    build_exp();
    obs_q.delete();
    pulse_start();
    for (int i = 0; i < 39; i++) send_move(mv_q[i], 1'b0);
    mv_valid = 1'b1;
    mv_data  = mv_q[39];
    repeat (3) @(negedge clk);
    n_cmp++; if (mv_ready !== 1'b0) begin n_bad++; $display("FAIL bp_stall: got mv_ready=%b expected 0", mv_ready); end
    pop_one(w);
    obs_q.push_back(w);
    n_cmp++; if (mv_ready !== 1'b1) begin n_bad++; $display("FAIL bp_resume: got mv_ready=%b expected 1", mv_ready); end
    gen_done = 1'b1;
    @(negedge clk);
    mv_valid = 1'b0;
    gen_done = 1'b0;
    drain(400, 70);
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL bp_drain_timeout: got timeout expected done"); end
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL bp_word_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL bp_word%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_push_pop_same_edge();
    logic [WW-1:0] w;
    mv_q.delete();
    for (int i = 0; i < 16; i++) mv_q.push_back(MW'($urandom));
    build_exp();
    obs_q.delete();
    pulse_start();
    for (int i = 0; i < 15; i++) send_move(mv_q[i], 1'b0);
    mv_valid = 1'b1;
    mv_data  = mv_q[15];
    rden     = 1'b1;
    n_cmp++; if (mv_ready !== 1'b1) begin n_bad++; $display("FAIL pp_ready: got %b expected 1", mv_ready); end
    @(negedge clk);
    mv_valid = 1'b0;
    rden     = 1'b0;
    n_cmp++; if (fifoOut !== exp_q[0]) begin n_bad++; $display("FAIL pp_head: got %h expected %h", fifoOut, exp_q[0]); end
    n_cmp++; if (fifoEmpty !== 1'b0) begin n_bad++; $display("FAIL pp_occupancy: got fifoEmpty=%b expected 0", fifoEmpty); end
    pop_one(w);
    n_cmp++; if (w !== exp_q[1]) begin n_bad++; $display("FAIL pp_second: got %h expected %h", w, exp_q[1]); end
    n_cmp++; if (fifoEmpty !== 1'b1) begin n_bad++; $display("FAIL pp_one_word: got fifoEmpty=%b expected 1", fifoEmpty); end
    pulse_gen_done();
    drain(100, 100);
    n_cmp++; if (obs_q.size() != 1 || timed_out) begin n_bad++; $display("FAIL pp_tail_count: got %0d words timeout=%b expected 1/0", obs_q.size(), timed_out); end
    if (obs_q.size() > 0) begin
      n_cmp++; if (obs_q[0] !== exp_q[2]) begin n_bad++; $display("FAIL pp_term: got %h expected %h", obs_q[0], exp_q[2]); end
    end
`ifdef LMG_MOVE_COUNT_EN
    n_cmp++; if (move_count !== 8'd16) begin n_bad++; $display("FAIL pp_move_count: got %0d expected 16", move_count); end
`endif
  endtask

  task automatic test_reset_mid_list();
    pulse_start();
    for (int i = 0; i < 5; i++) send_move(MW'($urandom), 1'b0);
    #3 reset_n = 1'b0;
    #1;
    n_cmp++; if (fifoEmpty !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL rst_mid_flags: got fifoEmpty=%b done=%b expected 1/0", fifoEmpty, done); end
    n_cmp++; if (fifoOut !== inv_word) begin n_bad++; $display("FAIL rst_mid_fifoOut: got %h expected %h", fifoOut, inv_word); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (mv_ready !== 1'b0) begin n_bad++; $display("FAIL rst_mid_idle: got mv_ready=%b expected 0", mv_ready); end
    mv_q = '{18'h3ABCD, 18'h00001, 18'h20000, 18'h15555};
    build_exp();
    obs_q.delete();
    pulse_start();
    drive_list(1'b1);
    drain(200, 100);
    n_cmp++; if (obs_q.size() != exp_q.size() || timed_out) begin n_bad++; $display("FAIL rst_new_count: got %0d timeout=%b expected %0d", obs_q.size(), timed_out, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rst_new_word%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_start_mid_list();
    pulse_start();
    for (int i = 0; i < 10; i++) send_move(MW'($urandom), 1'b0);
    pulse_start();
    n_cmp++; if (fifoEmpty !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL restart_flags: got fifoEmpty=%b done=%b expected 1/0", fifoEmpty, done); end
    mv_q.delete();
    for (int i = 0; i < 3; i++) mv_q.push_back(MW'($urandom));
    build_exp();
    obs_q.delete();
    drive_list(1'b0);
    drain(200, 100);
    n_cmp++; if (obs_q.size() != exp_q.size() || timed_out) begin n_bad++; $display("FAIL restart_count: got %0d timeout=%b expected %0d", obs_q.size(), timed_out, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL restart_word%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
`ifdef LMG_MOVE_COUNT_EN
    n_cmp++; if (move_count !== 8'd3) begin n_bad++; $display("FAIL restart_move_count: got %0d expected 3", move_count); end
`endif
  endtask

  // Random lists with a concurrent reader; includes the 218-move maximum and a count past 255.
  task automatic test_random_lists();
    int n;
    int pct;
    bit coin;
    for (int it = 0; it < 8; it++) begin
      n    = (it == 0) ? 218 : (it == 1) ? 260 : int'($urandom_range(0, 40));
      pct  = int'($urandom_range(30, 100));
      coin = 1'($urandom_range(0, 1));
      mv_q.delete();
      for (int i = 0; i < n; i++) mv_q.push_back(MW'($urandom));
      build_exp();
      obs_q.delete();
      pulse_start();
      fork
        drive_list(coin);
        drain(n * 20 + 500, pct);
      join
      n_cmp++; if (obs_q.size() != exp_q.size() || timed_out) begin n_bad++; $display("FAIL rand%0d_count: got %0d timeout=%b expected %0d", it, obs_q.size(), timed_out, exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        n_cmp++;
        if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand%0d_word%0d: got %h expected %h", it, i, obs_q[i], exp_q[i]); end
      end
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL rand%0d_done: got %b expected 1", it, done); end
`ifdef LMG_MOVE_COUNT_EN
      n_cmp++; if (move_count !== 8'((n > 255) ? 255 : n)) begin n_bad++; $display("FAIL rand%0d_move_count: got %0d expected %0d", it, move_count, (n > 255) ? 255 : n); end
`endif
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    inv_word = empty_word();
    test_reset();
    test_partial_word();
    test_full_word();
    test_empty_list();
    test_backpressure();
    test_push_pop_same_edge();
    test_reset_mid_list();
    test_start_mid_list();
    test_random_lists();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
